serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (legal range 1..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to add a and b; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured on the accepted start.
REQ-006 b  input  WIDTH  operand B; captured on the accepted start.
REQ-007 busy  output  1  high while the bit-serial addition is in progress (RUN).
REQ-008 done  output  1  single-cycle pulse; sum and cout valid.
REQ-009 sum  output  WIDTH  result a+b modulo 2^WIDTH.
REQ-010 cout  output  1  carry out of bit WIDTH-1.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-012 IDLE: when start=1, the block SHALL load a and b into operand shift registers, clear the carry flop, clear the bit counter and go to RUN; start=0 SHALL keep the FSM in IDLE.
REQ-013 RUN: each cycle, the block SHALL feed the operand LSBs and the carry flop through one full-adder cell.
REQ-014 RUN: each cycle, the sum bit SHALL shift into the result register MSB, both operand registers SHALL shift right by one, and the carry flop SHALL take the cell carry.
REQ-015 RUN: the bit counter SHALL increment each cycle; when it equals WIDTH-1, the next state SHALL be DONE.
REQ-016 DONE: done=1 for exactly one cycle; sum SHALL be the result register, cout the carry flop; the next state SHALL be IDLE unconditionally.
REQ-017 Latency: start sampled at edge k -> busy=1 for cycles k+1..k+WIDTH -> done=1 in cycle k+WIDTH+1.
REQ-018 start SHALL be ignored in RUN and DONE; operands SHALL be captured only in IDLE.
REQ-019 sum and cout SHALL hold their last values from DONE until the next accepted start completes.
REQ-020 A start asserted in the IDLE cycle immediately after DONE SHALL be accepted (back-to-back operation).
REQ-021 busy and done SHALL never be high in the same cycle.
REQ-022 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.
REQ-023 Carry arithmetic: WIDTH+1 result bits total; no saturation.
REQ-024 The bit counter SHALL be clog2(WIDTH) bits, minimum 1 bit.
REQ-025 For WIDTH=1, RUN SHALL last one cycle.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, sum=0, cout=0, carry flop=0, counter=0 and the operand registers to 0.
REQ-027 A reset asserted mid-RUN SHALL abort the operation with no done pulse; after release, the block SHALL wait in IDLE for a new start.
REQ-028 start SHALL be ignored while rst_n=0 and on the first edge at which rst_n is sampled high.

Structure
REQ-029 A shared package serial_add_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the constant DEFAULT_WIDTH=8.
REQ-030 One sub-module, fa_cell, SHALL implement a combinational full adder (inputs x, y, ci; outputs s, co) built from two instances of the team's existing half-adder cell and an OR of their carries.
REQ-031 serial_add_ctrl SHALL instantiate exactly one fa_cell; no other adder logic is permitted.

Verification
REQ-032 WIDTH=8: a=0x5A, b=0x3C, start for 1 cycle -> busy high for 8 cycles, done 9 cycles after start, sum=0x96, cout=0.
REQ-033 WIDTH=8: a=0xFF, b=0x01 -> sum=0x00, cout=1; a=0xFF, b=0xFF -> sum=0xFE, cout=1.
REQ-034 Start at edge k with a=0x11, b=0x22; start held high with a=0x70 during RUN -> one done only, sum=0x33; start seen again in the IDLE cycle after DONE -> new op accepted.
REQ-035 rst_n pulsed low at RUN bit 4 -> outputs 0 asynchronously, no done pulse; next start with a=0x03, b=0x04 -> sum=0x07, cout=0.
REQ-036 WIDTH=1: a=1, b=1 -> busy 1 cycle, done at start+2, sum=0, cout=1.
REQ-037 Random WIDTH=8 soak, 1000 ops -> {cout,sum}==a+b every op; busy and done never high together.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_if.sv
// Request/result bundle between a requester and serial_add_ctrl.
interface serial_add_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, input busy, done, sum, cout);
  modport slave  (input start, a, b, output busy, done, sum, cout);
endinterface

// File: rtl/half_add.sv
// Half-adder cell shared across the arithmetic blocks.
module half_add (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

// File: rtl/serial_add_ctrl_fa_cell.sv
// Combinational full adder built from two half-adder cells.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0;
  logic c0;
  logic c1;

  half_add u_ha0 (.x(x),  .y(y),  .s(s0), .c(c0));
  half_add u_ha1 (.x(s0), .y(ci), .s(s),  .c(c1));

  assign co = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell, LSB first, one bit per clock.
//   state | meaning
//   IDLE  | waiting for start; operands captured on accept
//   RUN   | one operand bit per cycle through the adder cell
//   DONE  | one-cycle done pulse, result presented on sum/cout
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_add_if.slave  bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   res_sr;
  logic [WIDTH-1:0]   res_nxt;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               ready;
  logic               load;
  logic               shift;
  logic               last;
  logic               fa_s;
  logic               fa_co;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;

  fa_cell u_fa (.x(a_sr[0]), .y(b_sr[0]), .ci(carry), .s(fa_s), .co(fa_co));

  assign last    = (cnt == CNT_W'(WIDTH - 1));
  assign res_nxt = WIDTH'({fa_s, res_sr} >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && ready) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        shift = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ready masks start on the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      ready  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      ready  <= 1'b1;
      busy_q <= (state_nxt == RUN);
      done_q <= (state_nxt == DONE);
      if (load) begin
        a_sr   <= bus.a;
        b_sr   <= bus.b;
        res_sr <= '0;
        carry  <= 1'b0;
        cnt    <= '0;
      end else if (shift) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        res_sr <= res_nxt;
        carry  <= fa_co;
        cnt    <= cnt + CNT_W'(1);
        if (last) begin
          sum_q  <= res_nxt;
          cout_q <= fa_co;
        end
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst_n;

  int n_tests = 0;
  int n_fail  = 0;
  int n_push  = 0;
  int done_seen = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  serial_add_if #(.WIDTH(8)) if8 ();
  serial_add_if #(.WIDTH(1)) if1 ();

  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("busy_done_excl", 32'(if8.busy & if8.done), 0);
      check("busy_done_excl_w1", 32'(if1.busy & if1.done), 0);
      if (if8.done) begin
        done_seen++;
        if (exp_q.size() == 0) check("spurious_done", 32'(if8.done), 0);
        else check("result", {if8.cout, if8.sum}, exp_q.pop_front());
      end
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    int lat;
    int bc;
    @(negedge clk);
    if8.a = a; if8.b = b; if8.start = 1'b1;
    exp_q.push_back({1'b0, a} + {1'b0, b});
    n_push++;
    @(negedge clk);
    if8.start = 1'b0;
    if8.a = 8'($urandom);
    if8.b = 8'($urandom);
    lat = 1; bc = 0;
    while (!if8.done && lat < 40) begin
      bc += int'(if8.busy);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 9);
    check("busy_cycles", bc, 8);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    if8.start = 1'b0; if8.a = '0; if8.b = '0;
    if1.start = 1'b0; if1.a = '0; if1.b = '0;
    #1;
    check("rst_busy", 32'(if8.busy), 0);
    check("rst_done", 32'(if8.done), 0);
    check("rst_sum", 32'(if8.sum), 0);
    check("rst_cout", 32'(if8.cout), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    op8(8'h5A, 8'h3C);
    repeat (3) @(negedge clk);
    check("sum_hold_idle", {if8.cout, if8.sum}, 9'h096);
    op8(8'hFF, 8'h01);
    op8(8'hFF, 8'hFF);
    op8(8'h00, 8'h00);

    // start held through RUN/DONE; re-accepted in the IDLE cycle after DONE
    @(negedge clk);
    if8.a = 8'h11; if8.b = 8'h22; if8.start = 1'b1;
    exp_q.push_back(9'h033); n_push++;
    @(negedge clk);
    if8.a = 8'h70;
    lat = 1;
    while (!if8.done && lat < 40) begin @(negedge clk); lat++; end
    check("held_start_latency", lat, 9);
    exp_q.push_back(9'h092); n_push++;
    @(negedge clk);
    check("sum_hold_after_done", 32'(if8.sum), 32'h33);
    check("idle_not_busy", 32'(if8.busy), 0);
    @(negedge clk);
    if8.start = 1'b0;
    check("b2b_busy", 32'(if8.busy), 1);
    lat = 1;
    while (!if8.done && lat < 40) begin @(negedge clk); lat++; end
    check("b2b_latency", lat, 9);

    // reset mid-RUN at bit 4
    @(negedge clk);
    @(negedge clk);
    if8.a = 8'h55; if8.b = 8'h0F; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_pre_rst", 32'(if8.busy), 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(if8.busy), 0);
    check("arst_done", 32'(if8.done), 0);
    check("arst_sum", 32'(if8.sum), 0);
    check("arst_cout", 32'(if8.cout), 0);
    if8.a = 8'h03; if8.b = 8'h04; if8.start = 1'b1;
    @(negedge clk);
    check("rst_start_ignored", 32'(if8.busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_edge_ignored", 32'(if8.busy), 0);
    exp_q.push_back(9'h007); n_push++;
    @(negedge clk);
    if8.start = 1'b0;
    check("post_rst_accept", 32'(if8.busy), 1);
    lat = 1;
    while (!if8.done && lat < 40) begin @(negedge clk); lat++; end
    check("post_rst_latency", lat, 9);

    // WIDTH=1 instance
    @(negedge clk);
    if1.a = 1'b1; if1.b = 1'b1; if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0; if1.a = 1'b0; if1.b = 1'b0;
    check("w1_busy", 32'(if1.busy), 1);
    check("w1_no_early_done", 32'(if1.done), 0);
    @(negedge clk);
    check("w1_done", 32'(if1.done), 1);
    check("w1_result", {if1.cout, if1.sum}, 2'b10);
    @(negedge clk);
    if1.a = 1'b1; if1.b = 1'b0; if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    @(negedge clk);
    check("w1_done2", 32'(if1.done), 1);
    check("w1_result2", {if1.cout, if1.sum}, 2'b01);

    for (int i = 0; i < 1000; i++) begin
      op8(8'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("done_count", done_seen, n_push);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
